// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl
// Owns the single write port of a branch-predictor pattern table made of
// CTR_W-bit saturating counters held in a synchronous-read RAM.
//
// After reset, or when init_req is pulsed, it sweeps the whole table and
// writes INIT_VAL to every entry. Otherwise it queues resolved-branch updates
// from EX in a small FIFO. Each update then passes through a 2-stage
// read-modify-write pipeline:
//   S1 pops the FIFO head and issues the table read.
//   S2 bumps the counter and writes it back.
// When two back-to-back updates hit the same index, S2 forwards the value it
// wrote in the previous cycle.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   init_req      one-cycle pulse, restart the full-table clear sweep
//   upd_valid     resolved branch update present
//   upd_idx       table index of the resolved branch
//   upd_taken     actual branch outcome
//   upd_ready     update accepted when upd_valid && upd_ready
//   tbl_re        table read enable
//   tbl_raddr     table read address (data arrives next cycle)
//   tbl_rdata     table read data (old data on same-cycle write collision)
//   tbl_we        table write enable
//   tbl_waddr     table write address
//   tbl_wdata     table write data
//   pred_en       table contents valid for lookups
//   busy          sweep running, FIFO non-empty, or S2 occupied
//   drop_cnt      saturating count of discarded updates
module bp_update_ctrl #(
  parameter int               IDX_W    = 8,
  parameter int               CTR_W    = 2,
  parameter logic [CTR_W-1:0] INIT_VAL = 2'b01,
  parameter int               QDEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_req,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             tbl_re,
  output logic [IDX_W-1:0] tbl_raddr,
  input  logic [CTR_W-1:0] tbl_rdata,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_waddr,
  output logic [CTR_W-1:0] tbl_wdata,
  output logic             pred_en,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0] fifoIdx_q [QDEPTH];
  logic             fifoTaken_q [QDEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2Valid_q, s2Valid_d;
  logic [IDX_W-1:0] s2Idx_q, s2Idx_d;
  logic             s2Taken_q, s2Taken_d;

  logic             prevWe_q;
  logic [IDX_W-1:0] prevWaddr_q;
  logic [CTR_W-1:0] prevWdata_q;

  logic [7:0]       dropCnt_q, dropCnt_d;

  logic             fifoFull, fifoEmpty, push, pop;
  logic [CTR_W-1:0] oldVal, newVal;
  logic [15:0]      dropAdd, dropSum;

  assign fifoFull  = (cnt_q == CNT_W'(QDEPTH));
  assign fifoEmpty = (cnt_q == '0);

  // S2 counter update. A read issued in the same cycle as a write to the
  // same index returns the old value. In that case the value written last
  // cycle is the true current one, so it overrides tbl_rdata.
  always_comb begin
    oldVal = tbl_rdata;
    if (prevWe_q && (prevWaddr_q == s2Idx_q)) begin
      oldVal = prevWdata_q;
    end
    newVal = oldVal;
    if (s2Taken_q) begin
      if (oldVal != CTR_MAX) newVal = oldVal + CTR_W'(1);
    end else begin
      if (oldVal != '0) newVal = oldVal - CTR_W'(1);
    end
  end

  // Next-state and output logic.
  // An init_req seen in RUN flushes everything in flight (FIFO, S2, and
  // the concurrent update) and suppresses this cycle's S2 write.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    cnt_d     = cnt_q;
    s2Valid_d = 1'b0;
    s2Idx_d   = s2Idx_q;
    s2Taken_d = s2Taken_q;
    push      = 1'b0;
    pop       = 1'b0;
    dropAdd   = '0;
    upd_ready = 1'b0;
    tbl_re    = 1'b0;
    tbl_raddr = fifoIdx_q[rdPtr_q];
    tbl_we    = 1'b0;
    tbl_waddr = s2Idx_q;
    tbl_wdata = newVal;

    case (state_q)
      INIT: begin
        tbl_we    = 1'b1;
        tbl_waddr = ptr_q;
        tbl_wdata = INIT_VAL;
        upd_ready = 1'b1;
        dropAdd   = 16'(upd_valid);
        if (init_req) begin
          ptr_d = '0;
        end else if (ptr_q == IDX_LAST) begin
          ptr_d   = '0;
          state_d = RUN;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      RUN: begin
        upd_ready = !fifoFull;
        if (init_req) begin
          state_d = INIT;
          ptr_d   = '0;
          wrPtr_d = '0;
          rdPtr_d = '0;
          cnt_d   = '0;
          dropAdd = 16'(cnt_q) + 16'(s2Valid_q) + 16'(upd_valid && !fifoFull);
        end else begin
          push      = upd_valid && !fifoFull;
          pop       = !fifoEmpty;
          tbl_re    = pop;
          s2Valid_d = pop;
          if (pop) begin
            s2Idx_d   = fifoIdx_q[rdPtr_q];
            s2Taken_d = fifoTaken_q[rdPtr_q];
            rdPtr_d   = rdPtr_q + PTR_W'(1);
          end
          if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
          cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
          tbl_we = s2Valid_q;
        end
      end
      default: state_d = INIT;
    endcase

    dropSum   = 16'(dropCnt_q) + dropAdd;
    dropCnt_d = (dropSum > 16'd255) ? 8'hFF : dropSum[7:0];

    // Keep the table port and handshake quiet while reset is held.
    if (reset) begin
      upd_ready = 1'b0;
      tbl_re    = 1'b0;
      tbl_we    = 1'b0;
    end
  end

  // State registers. The last write is also registered here so that S2 can
  // forward it in the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      ptr_q       <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      cnt_q       <= '0;
      s2Valid_q   <= 1'b0;
      s2Idx_q     <= '0;
      s2Taken_q   <= 1'b0;
      prevWe_q    <= 1'b0;
      prevWaddr_q <= '0;
      prevWdata_q <= '0;
      dropCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      cnt_q       <= cnt_d;
      s2Valid_q   <= s2Valid_d;
      s2Idx_q     <= s2Idx_d;
      s2Taken_q   <= s2Taken_d;
      prevWe_q    <= tbl_we;
      prevWaddr_q <= tbl_waddr;
      prevWdata_q <= tbl_wdata;
      dropCnt_q   <= dropCnt_d;
    end
  end

  // FIFO storage. It is never reset: the count and pointers alone decide
  // which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoIdx_q[wrPtr_q]   <= upd_idx;
      fifoTaken_q[wrPtr_q] <= upd_taken;
    end
  end

  assign pred_en  = (state_q == RUN);
  assign busy     = (state_q == INIT) || !fifoEmpty || s2Valid_q;
  assign drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Testbench for bp_update_ctrl.
// A behavioural synchronous-read RAM stands in for the pattern table. On a
// same-cycle read/write collision it returns the old data.
module tb_bp_update_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_req = 1'b0;
  logic       upd_valid = 1'b0;
  logic [7:0] upd_idx = '0;
  logic       upd_taken = 1'b0;
  logic       upd_ready;
  logic       tbl_re;
  logic [7:0] tbl_raddr;
  logic [1:0] tbl_rdata;
  logic       tbl_we;
  logic [7:0] tbl_waddr;
  logic [1:0] tbl_wdata;
  logic       pred_en;
  logic       busy;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [1:0] mem [256];

  bp_update_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .init_req  (init_req),
    .upd_valid (upd_valid),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken),
    .upd_ready (upd_ready),
    .tbl_re    (tbl_re),
    .tbl_raddr (tbl_raddr),
    .tbl_rdata (tbl_rdata),
    .tbl_we    (tbl_we),
    .tbl_waddr (tbl_waddr),
    .tbl_wdata (tbl_wdata),
    .pred_en   (pred_en),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Pattern-table model. Non-blocking assignments make a colliding read
  // return the pre-write contents.
  always @(posedge clk) begin
    if (tbl_re) tbl_rdata <= mem[tbl_raddr];
    if (tbl_we) mem[tbl_waddr] <= tbl_wdata;
  end

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset state, then the full 256-entry clear sweep and the switch to RUN.
  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    @(negedge clk);
    checks++;
    if (tbl_we !== 1'b0 || tbl_re !== 1'b0 || pred_en !== 1'b0 || drop_cnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: we=%b re=%b pred_en=%b drop=%0d, required 0 0 0 0",
               tbl_we, tbl_re, pred_en, drop_cnt);
    end
    tick;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      checks++;
      if (tbl_we !== 1'b1 || tbl_waddr !== 8'(i) || tbl_wdata !== 2'b01 ||
          pred_en !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL sweep[%0d]: we=%b addr=%0d data=%b pred_en=%b busy=%b, required 1 %0d 01 0 1",
                 i, tbl_we, tbl_waddr, tbl_wdata, pred_en, busy, i);
      end
      tick;
    end
    @(negedge clk);
    checks++;
    if (pred_en !== 1'b1 || busy !== 1'b0 || tbl_we !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sweep_done: pred_en=%b busy=%b we=%b, required 1 0 0",
               pred_en, busy, tbl_we);
    end
    tick;
  endtask

  // One taken update on idx 5. The write lands in the third cycle,
  // counting the handshake cycle as the first.
  task automatic test_single;
    upd_valid = 1'b1;
    upd_idx   = 8'd5;
    upd_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (upd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_ready: got %b, required 1", upd_ready);
    end
    tick;
    upd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tbl_re !== 1'b1 || tbl_raddr !== 8'd5 || tbl_we !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_issue: re=%b raddr=%0d we=%b, required 1 5 0",
               tbl_re, tbl_raddr, tbl_we);
    end
    tick;
    @(negedge clk);
    checks++;
    if (tbl_we !== 1'b1 || tbl_waddr !== 8'd5 || tbl_wdata !== 2'b10) begin
      failures++;
      $display("[TB] FAIL single_write: we=%b addr=%0d data=%b, required 1 5 10",
               tbl_we, tbl_waddr, tbl_wdata);
    end
    tick;
    @(negedge clk);
    checks++;
    if (tbl_we !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_idle: we=%b busy=%b, required 0 0", tbl_we, busy);
    end
    tick;
  endtask

  // Same-index streams on idx 7. Three taken updates from 01 exercise
  // forwarding and the ceiling. Four not-taken updates from 11 then walk
  // down to the floor and hold there.
  task automatic test_back_to_back;
    logic [1:0] expUp [3];
    logic [1:0] expDn [4];
    expUp = '{2'b10, 2'b11, 2'b11};
    expDn = '{2'b10, 2'b01, 2'b00, 2'b00};
    for (int k = 0; k < 5; k++) begin
      upd_valid = (k < 3);
      upd_idx   = 8'd7;
      upd_taken = 1'b1;
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (tbl_we !== 1'b1 || tbl_waddr !== 8'd7 || tbl_wdata !== expUp[k-2]) begin
          failures++;
          $display("[TB] FAIL b2b_taken[%0d]: we=%b addr=%0d data=%b, required 1 7 %b",
                   k - 2, tbl_we, tbl_waddr, tbl_wdata, expUp[k-2]);
        end
      end
      tick;
    end
    for (int k = 0; k < 6; k++) begin
      upd_valid = (k < 4);
      upd_idx   = 8'd7;
      upd_taken = 1'b0;
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (tbl_we !== 1'b1 || tbl_waddr !== 8'd7 || tbl_wdata !== expDn[k-2]) begin
          failures++;
          $display("[TB] FAIL b2b_nottaken[%0d]: we=%b addr=%0d data=%b, required 1 7 %b",
                   k - 2, tbl_we, tbl_waddr, tbl_wdata, expDn[k-2]);
        end
      end
      tick;
    end
    upd_valid = 1'b0;
  endtask

  // upd_valid held for six cycles on distinct indices with alternating
  // outcomes. Expect six in-order writes and ready held high throughout.
  task automatic test_stream;
    for (int k = 0; k < 9; k++) begin
      upd_valid = (k < 6);
      upd_idx   = 8'(20 + k);
      upd_taken = (k % 2 == 0);
      @(negedge clk);
      if (k < 6) begin
        checks++;
        if (upd_ready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL stream_ready[%0d]: got %b, required 1", k, upd_ready);
        end
      end
      if (k >= 2 && k < 8) begin
        checks++;
        if (tbl_we !== 1'b1 || tbl_waddr !== 8'(18 + k) ||
            tbl_wdata !== ((k % 2 == 0) ? 2'b10 : 2'b00)) begin
          failures++;
          $display("[TB] FAIL stream_write[%0d]: we=%b addr=%0d data=%b, required 1 %0d %b",
                   k - 2, tbl_we, tbl_waddr, tbl_wdata, 18 + k,
                   (k % 2 == 0) ? 2'b10 : 2'b00);
        end
      end
      if (k == 8) begin
        checks++;
        if (busy !== 1'b0 || tbl_we !== 1'b0) begin
          failures++;
          $display("[TB] FAIL stream_idle: busy=%b we=%b, required 0 0", busy, tbl_we);
        end
      end
      tick;
    end
  endtask

  // Updates A,B,C,D on idx 30..33, with init_req arriving together with D.
  // A is already written when init_req lands. B sits in S2, C waits in the
  // FIFO, and D is the concurrent update, so three are dropped.
  task automatic test_init_collision;
    for (int k = 0; k < 5; k++) begin
      upd_valid = (k < 4);
      upd_idx   = 8'(30 + k);
      upd_taken = 1'b1;
      init_req  = (k == 3);
      @(negedge clk);
      if (k == 2) begin
        checks++;
        if (tbl_we !== 1'b1 || tbl_waddr !== 8'd30 || tbl_wdata !== 2'b10) begin
          failures++;
          $display("[TB] FAIL coll_first_write: we=%b addr=%0d data=%b, required 1 30 10",
                   tbl_we, tbl_waddr, tbl_wdata);
        end
      end
      if (k == 3) begin
        checks++;
        if (tbl_we !== 1'b0 || pred_en !== 1'b1 || upd_ready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL coll_suppress: we=%b pred_en=%b ready=%b, required 0 1 1",
                   tbl_we, pred_en, upd_ready);
        end
      end
      if (k == 4) begin
        checks++;
        if (pred_en !== 1'b0 || busy !== 1'b1 || tbl_we !== 1'b1 ||
            tbl_waddr !== 8'd0 || tbl_wdata !== 2'b01) begin
          failures++;
          $display("[TB] FAIL coll_restart: pred_en=%b busy=%b we=%b addr=%0d data=%b, required 0 1 1 0 01",
                   pred_en, busy, tbl_we, tbl_waddr, tbl_wdata);
        end
        checks++;
        if (drop_cnt !== 8'd3) begin
          failures++;
          $display("[TB] FAIL coll_drops: got %0d, required 3", drop_cnt);
        end
      end
      tick;
    end
    init_req = 1'b0;
  endtask

  // 300 update pulses during the sweep, with an init_req at ptr 100.
  // drop_cnt starts this task at 3 and saturates at 255.
  task automatic test_drop_saturation;
    for (int j = 0; j < 300; j++) begin
      upd_valid = 1'b1;
      upd_idx   = 8'(j);
      init_req  = (j == 99);
      @(negedge clk);
      if (j == 0) begin
        checks++;
        if (upd_ready !== 1'b1 || tbl_waddr !== 8'd1) begin
          failures++;
          $display("[TB] FAIL sat_init_ready: ready=%b addr=%0d, required 1 1", upd_ready, tbl_waddr);
        end
      end
      if (j == 99) begin
        checks++;
        if (tbl_waddr !== 8'd100) begin
          failures++;
          $display("[TB] FAIL sat_ptr100: got %0d, required 100", tbl_waddr);
        end
      end
      if (j == 100) begin
        checks++;
        if (tbl_waddr !== 8'd0 || tbl_we !== 1'b1) begin
          failures++;
          $display("[TB] FAIL sat_restart: addr=%0d we=%b, required 0 1", tbl_waddr, tbl_we);
        end
      end
      if (j == 50 || j == 251 || j == 252 || j == 299) begin
        checks++;
        if (drop_cnt !== ((3 + j > 255) ? 8'd255 : 8'(3 + j))) begin
          failures++;
          $display("[TB] FAIL sat_drops[%0d]: got %0d, required %0d",
                   j, drop_cnt, (3 + j > 255) ? 255 : 3 + j);
        end
      end
      tick;
    end
    upd_valid = 1'b0;
    init_req  = 1'b0;
  endtask

  // Reset during the sweep, then again at ptr 100. Each reset restarts the
  // sweep at 0 with drop_cnt cleared, and the final sweep runs to RUN.
  task automatic test_reset_midsweep;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (drop_cnt !== 8'd0 || pred_en !== 1'b0) begin
          failures++;
          $display("[TB] FAIL mid_reset_state: drop=%0d pred_en=%b, required 0 0", drop_cnt, pred_en);
        end
      end
      checks++;
      if (tbl_we !== 1'b1 || tbl_waddr !== 8'(i)) begin
        failures++;
        $display("[TB] FAIL mid_sweep_a[%0d]: we=%b addr=%0d, required 1 %0d", i, tbl_we, tbl_waddr, i);
      end
      tick;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tbl_we !== 1'b0 || tbl_waddr !== 8'd100) begin
      failures++;
      $display("[TB] FAIL mid_reset_at100: we=%b addr=%0d, required 0 100", tbl_we, tbl_waddr);
    end
    tick;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      checks++;
      if (tbl_we !== 1'b1 || tbl_waddr !== 8'(i) || tbl_wdata !== 2'b01 || pred_en !== 1'b0) begin
        failures++;
        $display("[TB] FAIL mid_sweep_b[%0d]: we=%b addr=%0d data=%b pred_en=%b, required 1 %0d 01 0",
                 i, tbl_we, tbl_waddr, tbl_wdata, pred_en, i);
      end
      tick;
    end
    @(negedge clk);
    checks++;
    if (pred_en !== 1'b1 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL mid_done: pred_en=%b busy=%b drop=%0d, required 1 0 0",
               pred_en, busy, drop_cnt);
    end
    tick;
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] bp_update_ctrl bench start");
    test_reset;
    test_single;
    test_back_to_back;
    test_stream;
    test_init_collision;
    test_drop_saturation;
    test_reset_midsweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
